// File: rtl/rename_pkg.sv
// Shared types and constants for the rename/dispatch stage: RAT entry layout,
// default geometry and the zero-register predicate.
package rename_pkg;

  localparam int NUM_AR = 32;
  localparam int AR_W   = $clog2(NUM_AR);
  localparam int TAG_W  = 8;
  localparam int XLEN   = 64;
  localparam int FLAG_W = 13;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } rat_entry_t;

  // AR 0 is hardwired to zero only when the zero register is enabled
  function automatic logic arch_is_zero(input logic [AR_W-1:0] ar, input logic zero_en);
    return zero_en & (ar == {AR_W{1'b0}});
  endfunction

endpackage

// File: rtl/rename_src_lookup.sv
// Per-source operand resolution: zero register, commit bypass, in-flight tag
// or committed ARF value, in that priority order.
module rename_src_lookup
  import rename_pkg::*;
#(
  parameter int AR_W        = rename_pkg::AR_W,
  parameter int TAG_W       = rename_pkg::TAG_W,
  parameter int XLEN        = rename_pkg::XLEN,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic [AR_W-1:0]  ar,
  input  rat_entry_t       rat_ent,
  input  logic [XLEN-1:0]  arf_val,
  input  logic             cmt_ok,
  input  logic [AR_W-1:0]  cmt_arf,
  input  logic [TAG_W-1:0] cmt_tag,
  input  logic [XLEN-1:0]  cmt_result,
  output logic [TAG_W-1:0] src_tag,
  output logic             src_rdy,
  output logic [XLEN-1:0]  src_val
);

  logic zero_s;
  logic bypass_s;

  assign zero_s   = arch_is_zero(ar, ZERO_REG_EN);
  // Bypass only the retirement of the exact producer the RAT still points at
  assign bypass_s = cmt_ok & rat_ent.busy & (cmt_arf == ar) & (cmt_tag == rat_ent.tag);

  // Operand mux; the tag is forwarded unchanged and only matters when not ready
  always_comb begin
    src_tag = rat_ent.tag;
    src_rdy = 1'b1;
    src_val = arf_val;
    if (zero_s) begin
      src_rdy = 1'b1;
      src_val = {XLEN{1'b0}};
    end else if (bypass_s) begin
      src_rdy = 1'b1;
      src_val = cmt_result;
    end else if (rat_ent.busy) begin
      src_rdy = 1'b0;
      src_val = arf_val;
    end else begin
      src_rdy = 1'b1;
      src_val = arf_val;
    end
  end

endmodule

// File: rtl/rename_rat_arf.sv
// Rename/dispatch stage: RAT with in-flight bits, on-block ARF, RoB allocation
// handshake, tag-qualified release at commit and exception flush.
module rename_rat_arf
  import rename_pkg::*;
#(
  parameter int NUM_AR      = rename_pkg::NUM_AR,
  parameter int AR_W        = $clog2(NUM_AR),
  parameter int TAG_W       = rename_pkg::TAG_W,
  parameter int XLEN        = rename_pkg::XLEN,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AR_W-1:0]   src1_ar,
  input  logic [AR_W-1:0]   src2_ar,
  input  logic [AR_W-1:0]   dst_ar,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [TAG_W-1:0]  src1_tag,
  output logic [TAG_W-1:0]  src2_tag,
  output logic              src1_rdy,
  output logic              src2_rdy,
  output logic [XLEN-1:0]   src1_val,
  output logic [XLEN-1:0]   src2_val,
  output logic [TAG_W-1:0]  dst_tag,
  output logic [XLEN-1:0]   pc_out,
  output logic              valid_out,
  input  logic [TAG_W-1:0]  next_free,
  input  logic              is_free,
  output logic [AR_W-1:0]   alloc_arf,
  output logic [XLEN-1:0]   alloc_pc,
  output logic              do_alloc,
  input  logic [AR_W-1:0]   commit_arf,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic [XLEN-1:0]   commit_result,
  input  logic [FLAG_W-1:0] commit_flags,
  input  logic              commit_valid
);

  rat_entry_t      rat_r [NUM_AR];
  logic [XLEN-1:0] arf_r [NUM_AR];

  logic             flush_s;
  logic             cmt_ok_s;
  logic             cmt_release_s;
  logic             cmt_arf_zero_s;
  logic             dst_zero_s;
  logic [TAG_W-1:0] s1_tag_s;
  logic [TAG_W-1:0] s2_tag_s;
  logic             s1_rdy_s;
  logic             s2_rdy_s;
  logic [XLEN-1:0]  s1_val_s;
  logic [XLEN-1:0]  s2_val_s;

  assign flush_s        = commit_valid & (commit_flags != {FLAG_W{1'b0}});
  assign cmt_ok_s       = commit_valid & ~flush_s;
  assign cmt_arf_zero_s = arch_is_zero(commit_arf, ZERO_REG_EN);
  assign dst_zero_s     = arch_is_zero(dst_ar, ZERO_REG_EN);
  // A younger rename of the same AR leaves a different tag, so the entry stays busy
  assign cmt_release_s  = cmt_ok_s & ~cmt_arf_zero_s & (rat_r[commit_arf].tag == commit_tag);

  assign ready_out = ~reset & ~flush_s & is_free;
  assign do_alloc  = valid_in & ready_out;
  assign alloc_arf = dst_ar;
  assign alloc_pc  = pc_in;

  rename_src_lookup #(
    .AR_W(AR_W), .TAG_W(TAG_W), .XLEN(XLEN), .ZERO_REG_EN(ZERO_REG_EN)
  ) u_src1 (
    .ar(src1_ar), .rat_ent(rat_r[src1_ar]), .arf_val(arf_r[src1_ar]),
    .cmt_ok(cmt_ok_s), .cmt_arf(commit_arf), .cmt_tag(commit_tag),
    .cmt_result(commit_result),
    .src_tag(s1_tag_s), .src_rdy(s1_rdy_s), .src_val(s1_val_s)
  );

  rename_src_lookup #(
    .AR_W(AR_W), .TAG_W(TAG_W), .XLEN(XLEN), .ZERO_REG_EN(ZERO_REG_EN)
  ) u_src2 (
    .ar(src2_ar), .rat_ent(rat_r[src2_ar]), .arf_val(arf_r[src2_ar]),
    .cmt_ok(cmt_ok_s), .cmt_arf(commit_arf), .cmt_tag(commit_tag),
    .cmt_result(commit_result),
    .src_tag(s2_tag_s), .src_rdy(s2_rdy_s), .src_val(s2_val_s)
  );

  // RAT update: release at commit first, so a same-cycle rename overrides it
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_AR; i++) begin
        rat_r[i] <= '{busy: 1'b0, tag: {TAG_W{1'b0}}};
      end
    end else if (flush_s) begin
      for (int i = 0; i < NUM_AR; i++) begin
        rat_r[i].busy <= 1'b0;
      end
    end else begin
      if (cmt_release_s) begin
        rat_r[commit_arf].busy <= 1'b0;
      end
      if (do_alloc && !dst_zero_s) begin
        rat_r[dst_ar] <= '{busy: 1'b1, tag: next_free};
      end
    end
  end

  // ARF write on every non-excepting retirement
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_AR; i++) begin
        arf_r[i] <= {XLEN{1'b0}};
      end
    end else if (cmt_ok_s && !cmt_arf_zero_s) begin
      arf_r[commit_arf] <= commit_result;
    end
  end

  // Dispatch register; payload holds while no instruction is allocated
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out <= 1'b0;
      dst_tag   <= {TAG_W{1'b0}};
      pc_out    <= {XLEN{1'b0}};
      src1_tag  <= {TAG_W{1'b0}};
      src2_tag  <= {TAG_W{1'b0}};
      src1_rdy  <= 1'b0;
      src2_rdy  <= 1'b0;
      src1_val  <= {XLEN{1'b0}};
      src2_val  <= {XLEN{1'b0}};
    end else if (do_alloc) begin
      valid_out <= 1'b1;
      dst_tag   <= next_free;
      pc_out    <= pc_in;
      src1_tag  <= s1_tag_s;
      src2_tag  <= s2_tag_s;
      src1_rdy  <= s1_rdy_s;
      src2_rdy  <= s2_rdy_s;
      src1_val  <= s1_val_s;
      src2_val  <= s2_val_s;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_rat_arf.sv
// Directed self-checking bench for rename_rat_arf with hand-computed expectations.
module tb_rename_rat_arf;

  logic        clock;
  logic        reset;
  logic [4:0]  src1_ar, src2_ar, dst_ar;
  logic [63:0] pc_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  src1_tag, src2_tag;
  logic        src1_rdy, src2_rdy;
  logic [63:0] src1_val, src2_val;
  logic [7:0]  dst_tag;
  logic [63:0] pc_out;
  logic        valid_out;
  logic [7:0]  next_free;
  logic        is_free;
  logic [4:0]  alloc_arf;
  logic [63:0] alloc_pc;
  logic        do_alloc;
  logic [4:0]  commit_arf;
  logic [7:0]  commit_tag;
  logic [63:0] commit_result;
  logic [12:0] commit_flags;
  logic        commit_valid;

  int n_checks = 0;
  int n_errors = 0;

  rename_rat_arf dut (
    .clock(clock), .reset(reset),
    .src1_ar(src1_ar), .src2_ar(src2_ar), .dst_ar(dst_ar),
    .pc_in(pc_in), .valid_in(valid_in), .ready_out(ready_out),
    .src1_tag(src1_tag), .src2_tag(src2_tag),
    .src1_rdy(src1_rdy), .src2_rdy(src2_rdy),
    .src1_val(src1_val), .src2_val(src2_val),
    .dst_tag(dst_tag), .pc_out(pc_out), .valid_out(valid_out),
    .next_free(next_free), .is_free(is_free),
    .alloc_arf(alloc_arf), .alloc_pc(alloc_pc), .do_alloc(do_alloc),
    .commit_arf(commit_arf), .commit_tag(commit_tag),
    .commit_result(commit_result), .commit_flags(commit_flags),
    .commit_valid(commit_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    valid_in     = 1'b0;
    commit_valid = 1'b0;
    commit_flags = 13'h0;
    is_free      = 1'b1;
  endtask

  task automatic send(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input logic [7:0] nf, input logic [63:0] pc);
    valid_in  = 1'b1;
    src1_ar   = s1;
    src2_ar   = s2;
    dst_ar    = d;
    next_free = nf;
    pc_in     = pc;
  endtask

  task automatic commit(input logic [4:0] a, input logic [7:0] t,
                        input logic [63:0] r, input logic [12:0] f);
    commit_valid  = 1'b1;
    commit_arf    = a;
    commit_tag    = t;
    commit_result = r;
    commit_flags  = f;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    commit_arf = 5'd0; commit_tag = 8'h0; commit_result = 64'h0;
    send(5'd1, 5'd2, 5'd3, 8'h55, 64'h50);
    tick(); tick();
    check_eq("rst_ready", {63'd0, ready_out}, 64'd0);
    check_eq("rst_do_alloc", {63'd0, do_alloc}, 64'd0);
    check_eq("rst_valid_out", {63'd0, valid_out}, 64'd0);
    check_eq("rst_dst_tag", {56'd0, dst_tag}, 64'd0);
    check_eq("rst_pc_out", pc_out, 64'd0);
    reset = 1'b0;
    idle_in();
    tick();

    // first rename of r5
    send(5'd1, 5'd2, 5'd5, 8'h10, 64'h100);
    #1;
    check_eq("a_do_alloc", {63'd0, do_alloc}, 64'd1);
    check_eq("a_alloc_arf", {59'd0, alloc_arf}, 64'd5);
    check_eq("a_alloc_pc", alloc_pc, 64'h100);
    tick();
    check_eq("a_valid_out", {63'd0, valid_out}, 64'd1);
    check_eq("a_dst_tag", {56'd0, dst_tag}, 64'h10);
    check_eq("a_pc_out", pc_out, 64'h100);
    check_eq("a_src1_rdy", {63'd0, src1_rdy}, 64'd1);
    check_eq("a_src1_val", src1_val, 64'd0);

    send(5'd5, 5'd0, 5'd6, 8'h11, 64'h104);
    tick();
    check_eq("b_src1_rdy", {63'd0, src1_rdy}, 64'd0);
    check_eq("b_src1_tag", {56'd0, src1_tag}, 64'h10);
    check_eq("b_dst_tag", {56'd0, dst_tag}, 64'h11);

    // commit bypass into a same-cycle reader
    send(5'd5, 5'd6, 5'd8, 8'h12, 64'h108);
    commit(5'd5, 8'h10, 64'hDEAD, 13'h0);
    tick();
    idle_in();
    check_eq("c_src1_rdy", {63'd0, src1_rdy}, 64'd1);
    check_eq("c_src1_val", src1_val, 64'hDEAD);
    check_eq("c_src2_rdy", {63'd0, src2_rdy}, 64'd0);
    check_eq("c_src2_tag", {56'd0, src2_tag}, 64'h11);

    send(5'd5, 5'd0, 5'd0, 8'h13, 64'h10C);
    tick();
    check_eq("d_src1_rdy", {63'd0, src1_rdy}, 64'd1);
    check_eq("d_src1_val", src1_val, 64'hDEAD);

    // r7 renamed twice; the older commit must not release it
    send(5'd0, 5'd0, 5'd7, 8'h20, 64'h110);
    tick();
    send(5'd0, 5'd0, 5'd7, 8'h21, 64'h114);
    tick();
    send(5'd7, 5'd0, 5'd0, 8'h22, 64'h118);
    commit(5'd7, 8'h20, 64'h77, 13'h0);
    tick();
    idle_in();
    check_eq("e_src1_rdy_byp", {63'd0, src1_rdy}, 64'd0);
    check_eq("e_src1_tag_byp", {56'd0, src1_tag}, 64'h21);
    send(5'd7, 5'd0, 5'd0, 8'h23, 64'h11C);
    tick();
    check_eq("e_src1_rdy", {63'd0, src1_rdy}, 64'd0);
    check_eq("e_src1_tag", {56'd0, src1_tag}, 64'h21);

    // RoB full back-pressure
    send(5'd0, 5'd0, 5'd10, 8'h30, 64'h120);
    is_free = 1'b0;
    #1;
    check_eq("f_ready_out", {63'd0, ready_out}, 64'd0);
    check_eq("f_do_alloc", {63'd0, do_alloc}, 64'd0);
    tick();
    check_eq("f_valid_out", {63'd0, valid_out}, 64'd0);
    check_eq("f_dst_tag_hold", {56'd0, dst_tag}, 64'h23);
    is_free = 1'b1;
    #1;
    check_eq("f_do_alloc_go", {63'd0, do_alloc}, 64'd1);
    tick();
    check_eq("f_valid_out_go", {63'd0, valid_out}, 64'd1);
    check_eq("f_dst_tag_go", {56'd0, dst_tag}, 64'h30);

    // exception flush from the r7 producer
    send(5'd0, 5'd0, 5'd11, 8'h40, 64'h124);
    commit(5'd7, 8'h21, 64'hBAD, 13'h4);
    #1;
    check_eq("g_ready_out", {63'd0, ready_out}, 64'd0);
    check_eq("g_do_alloc", {63'd0, do_alloc}, 64'd0);
    tick();
    idle_in();
    check_eq("g_valid_out", {63'd0, valid_out}, 64'd0);
    send(5'd7, 5'd6, 5'd0, 8'h41, 64'h128);
    tick();
    check_eq("g_src1_rdy", {63'd0, src1_rdy}, 64'd1);
    check_eq("g_src1_val", src1_val, 64'h77);
    check_eq("g_src2_rdy", {63'd0, src2_rdy}, 64'd1);
    check_eq("g_src2_val", src2_val, 64'd0);
    send(5'd10, 5'd5, 5'd0, 8'h42, 64'h12C);
    tick();
    check_eq("g_src1_rdy_r10", {63'd0, src1_rdy}, 64'd1);
    check_eq("g_src2_val_r5", src2_val, 64'hDEAD);

    // src==dst and same-cycle rename+commit to one AR
    send(5'd12, 5'd0, 5'd12, 8'h60, 64'h130);
    tick();
    check_eq("h_src1_rdy_old", {63'd0, src1_rdy}, 64'd1);
    send(5'd12, 5'd0, 5'd12, 8'h61, 64'h134);
    commit(5'd12, 8'h60, 64'h5, 13'h0);
    tick();
    idle_in();
    check_eq("h_src1_rdy_byp", {63'd0, src1_rdy}, 64'd1);
    check_eq("h_src1_val_byp", src1_val, 64'h5);
    send(5'd12, 5'd0, 5'd0, 8'h62, 64'h138);
    tick();
    check_eq("h_src1_rdy_new", {63'd0, src1_rdy}, 64'd0);
    check_eq("h_src1_tag_new", {56'd0, src1_tag}, 64'h61);

    // hardwired zero register
    send(5'd0, 5'd0, 5'd0, 8'h70, 64'h140);
    tick();
    check_eq("i_src1_rdy", {63'd0, src1_rdy}, 64'd1);
    check_eq("i_src1_val", src1_val, 64'd0);
    send(5'd0, 5'd0, 5'd0, 8'h71, 64'h144);
    commit(5'd0, 8'h70, 64'h1, 13'h0);
    tick();
    idle_in();
    check_eq("i_src1_val_cmt", src1_val, 64'd0);
    send(5'd0, 5'd0, 5'd0, 8'h72, 64'h148);
    tick();
    check_eq("i_src1_rdy_after", {63'd0, src1_rdy}, 64'd1);
    check_eq("i_src1_val_after", src1_val, 64'd0);
    idle_in();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rename_rat_arf.md
Name: rename_rat_arf

Overview:
- Parametrised rename/dispatch stage between Fetch and the RoB/issue window.
- Translates source and destination architectural registers through a register alias table (RAT) that carries a per-entry in-flight bit.
- Supplies source operands either as a RoB tag or as the committed value read from an on-block ARF.
- Adds over the previous stage: RoB-full stall, tag-qualified RAT release at commit, commit-to-rename bypass, exception flush, and a hardwired zero register.

Parameters:
- NUM_AR, 32, number of architectural registers.
- AR_W, $clog2(NUM_AR), architectural register index width.
- TAG_W, 8, physical register / RoB index width.
- XLEN, 64, data and PC width.
- ZERO_REG_EN, 1, when 1, AR 0 always reads 0 and is never renamed.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- src1_ar, src2_ar, dst_ar  in  AR_W each  architectural registers of the incoming instruction.
- pc_in  in  XLEN  instruction address.
- valid_in  in  1  Fetch presents an instruction.
- ready_out  out  1  stage accepts this cycle (combinational).
- src1_tag, src2_tag  out  TAG_W each  producer RoB tag.
- src1_rdy, src2_rdy  out  1 each  1 = value in srcN_val; 0 = wait on srcN_tag.
- src1_val, src2_val  out  XLEN each  committed operand value.
- dst_tag  out  TAG_W  allocated RoB tag.
- pc_out  out  XLEN  dispatched PC.
- valid_out  out  1  dispatch valid.
- next_free  in  TAG_W  RoB tail index.
- is_free  in  1  RoB has a free entry.
- alloc_arf  out  AR_W  equals dst_ar.
- alloc_pc  out  XLEN  equals pc_in.
- do_alloc  out  1  advance RoB tail.
- commit_arf  in  AR_W  retiring architectural register.
- commit_tag  in  TAG_W  RoB index of the retiring entry.
- commit_result  in  XLEN  value to commit.
- commit_flags  in  13  exception code; nonzero = exception.
- commit_valid  in  1  retirement this cycle.

Behaviour:
- Reset: every RAT entry {busy=0, tag=0}; every ARF entry 0. All registered outputs 0, including valid_out. ready_out=0 and do_alloc=0 while reset is high.
- Definitions:
  - flush = commit_valid & (commit_flags != 0).
  - ready_out = !reset & !flush & is_free.
  - do_alloc = valid_in & ready_out. alloc_arf and alloc_pc are combinational pass-throughs.
- Latency: one cycle. On the posedge where do_alloc=1, outputs register: valid_out=1, dst_tag=next_free, pc_out=pc_in, and source fields. Otherwise valid_out=0 and the other outputs hold.
- Source lookup, per source, evaluated on pre-edge state:
  - RAT[ar].busy=0: rdy=1, val=ARF[ar].
  - RAT[ar].busy=1 and no commit match: rdy=0, tag=RAT[ar].tag.
  - Commit bypass: non-flush commit_valid with commit_arf==ar and commit_tag==RAT[ar].tag gives rdy=1, val=commit_result.
  - ZERO_REG_EN and ar==0: rdy=1, val=0.
- src==dst in the same instruction: the source sees the old mapping.
- RAT rename write: on do_alloc, RAT[dst_ar] <= {1, next_free}. Skipped when ZERO_REG_EN and dst_ar==0.
- Retirement, non-flush commit_valid:
  - ARF[commit_arf] <= commit_result; not written for AR 0 when ZERO_REG_EN.
  - RAT[commit_arf].busy <= 0 only if RAT[commit_arf].tag==commit_tag, i.e. no younger writer.
- Same-cycle rename and commit to the same AR: the rename write wins, leaving busy=1 with the new tag.
- Flush:
  - ARF is not written by the excepting instruction.
  - All RAT busy bits clear next cycle; tags are don't-care.
  - valid_out=0 and no allocation that cycle.
  - The first instruction after the flush reads ARF values.
- Back-pressure: valid_in & !is_free gives no allocation, valid_out=0 next cycle, and no state change. Fetch holds its inputs.
- No internal FSM beyond the RAT/ARF arrays and output registers. Reset asserted mid-stream overrides rename, commit and flush.

Decomposition:
- Shared package rename_pkg holds:
  - constants: NUM_AR, TAG_W, XLEN, FLAG_W=13;
  - typedef rat_entry_t {logic busy; logic [TAG_W-1:0] tag;};
  - function arch_is_zero().
- One natural sub-module, rename_src_lookup, instantiated twice. It contains the per-source mux covering RAT, ARF, commit bypass and zero register.
- The RAT and ARF arrays stay in the top level.

Test Plan:
- Reset, then rename dst=5 with next_free=8'h10 -> next cycle valid_out=1, dst_tag=8'h10. A following instruction with src1=5 -> src1_rdy=0, src1_tag=8'h10.
- Commit arf=5, tag=8'h10, result=64'hDEAD with src1=5 in the same cycle -> src1_rdy=1, src1_val=64'hDEAD; afterwards RAT[5].busy=0 and ARF[5]=64'hDEAD.
- Rename r7 twice, tags 8'h20 then 8'h21, then commit tag 8'h20 -> RAT[7] stays busy with tag 8'h21; ARF[7] is updated.
- is_free=0 with valid_in=1 -> ready_out=0, do_alloc=0, valid_out=0. Raising is_free gives dispatch one cycle later.
- Commit with commit_flags=13'h4 -> do_alloc=0 that cycle and ARF is unchanged. Next, src=any previously renamed AR -> rdy=1 with the ARF value.
- With ZERO_REG_EN=1, dst=0 with src1=0 -> RAT[0] is not written and src1_rdy=1, src1_val=0. Commit to AR 0 with result 64'h1 leaves ARF[0]=0.
